// File: rtl/hit_sound_sequencer.sv
// Enemy-hit note sequencer: per-class rising-edge hit detect, priority queueing, square-wave notes.
// Optional HIT_SOUND_SWEEP_EN: the half-period grows on every ms tick during a note.
module hit_sound_sequencer #(
  parameter int unsigned BULLET_COUNT = 8,
  parameter int unsigned TICK_DIV     = 25000,
  parameter int unsigned NOTE_MS      = 60,
  parameter int unsigned GAP_MS       = 10,
  parameter int unsigned HP_SPIDER    = 56818,
  parameter int unsigned HP_MOSQ      = 18939,
  parameter int unsigned HP_FLY       = 28409
`ifdef HIT_SOUND_SWEEP_EN
  , parameter int unsigned SWEEP_STEP = 400
`endif
) (
  input  logic                    clk25,
  input  logic                    reset_n,
  input  logic                    mute,
  input  logic [BULLET_COUNT-1:0] hit_fly,
  input  logic [BULLET_COUNT-1:0] hit_mosquito,
  input  logic [BULLET_COUNT-1:0] hit_spider,
  output logic                    buzz,
  output logic                    busy,
  output logic [2:0]              pending,
  output logic [1:0]              note_id
);

  localparam int unsigned HP_W   = 17;
  localparam int unsigned TICK_W = 15;
  localparam int unsigned MS_W   = 8;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_prev, w_hit_or, w_ev;
  logic [2:0]        r_pending, w_pending_nxt, w_clr;
  logic [HP_W-1:0]   r_hp, w_hp_nxt, r_half, w_half_nxt;
  logic [TICK_W-1:0] r_tick, w_tick_nxt;
  logic [MS_W-1:0]   r_ms, w_ms_nxt;
  logic              r_buzz, w_buzz_nxt, r_busy, w_busy_nxt;
  logic [1:0]        r_note, w_note_nxt;
  logic              w_ms_tick;
`ifdef HIT_SOUND_SWEEP_EN
  logic [HP_W:0]     w_hp_sum;
`endif

  assign w_hit_or  = {|hit_spider, |hit_mosquito, |hit_fly};
  assign w_ev      = w_hit_or & ~r_prev;
  assign w_ms_tick = (r_tick == TICK_W'(TICK_DIV - 1));

  // Next-state and next-register values; mute overrides everything at the end.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 3'b000;
    w_hp_nxt    = r_hp;
    w_half_nxt  = r_half;
    w_tick_nxt  = w_ms_tick ? '0 : r_tick + TICK_W'(1);
    w_ms_nxt    = r_ms;
    w_buzz_nxt  = r_buzz;
    w_note_nxt  = r_note;
`ifdef HIT_SOUND_SWEEP_EN
    w_hp_sum    = '0;
`endif
    case (r_state)
      S_IDLE: begin
        w_tick_nxt = '0;
        if (r_pending != 3'b000) begin
          w_state_nxt = S_PLAY;
          w_half_nxt  = '0;
          w_ms_nxt    = '0;
          if (r_pending[2]) begin
            w_clr = 3'b100; w_hp_nxt = HP_W'(HP_SPIDER); w_note_nxt = 2'd3;
          end else if (r_pending[1]) begin
            w_clr = 3'b010; w_hp_nxt = HP_W'(HP_MOSQ);   w_note_nxt = 2'd2;
          end else begin
            w_clr = 3'b001; w_hp_nxt = HP_W'(HP_FLY);    w_note_nxt = 2'd1;
          end
        end
      end
      S_PLAY: begin
        if (r_half == r_hp - HP_W'(1)) begin
          w_buzz_nxt = ~r_buzz;
          w_half_nxt = '0;
        end else begin
          w_half_nxt = r_half + HP_W'(1);
        end
`ifdef HIT_SOUND_SWEEP_EN
        if (w_ms_tick) begin
          w_hp_sum   = {1'b0, r_hp} + (HP_W+1)'(SWEEP_STEP);
          w_hp_nxt   = w_hp_sum[HP_W] ? {HP_W{1'b1}} : w_hp_sum[HP_W-1:0];
          w_half_nxt = '0;
        end
`endif
        if (w_ms_tick) begin
          if (r_ms == MS_W'(NOTE_MS - 1)) begin
            w_state_nxt = S_GAP;
            w_buzz_nxt  = 1'b0;
            w_ms_nxt    = '0;
            w_half_nxt  = '0;
          end else begin
            w_ms_nxt = r_ms + MS_W'(1);
          end
        end
      end
      S_GAP: begin
        if (w_ms_tick) begin
          if (r_ms == MS_W'(GAP_MS - 1)) begin
            w_state_nxt = S_IDLE;
            w_note_nxt  = 2'd0;
            w_ms_nxt    = '0;
          end else begin
            w_ms_nxt = r_ms + MS_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Set beats clear so an event arriving on the dispatch edge survives.
    w_pending_nxt = (r_pending & ~w_clr) | w_ev;

    if (mute) begin
      w_state_nxt   = S_IDLE;
      w_buzz_nxt    = 1'b0;
      w_note_nxt    = 2'd0;
      w_pending_nxt = 3'b000;
      w_half_nxt    = '0;
      w_tick_nxt    = '0;
      w_ms_nxt      = '0;
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_prev    <= 3'b000;
      r_pending <= 3'b000;
      r_hp      <= '0;
      r_half    <= '0;
      r_tick    <= '0;
      r_ms      <= '0;
      r_buzz    <= 1'b0;
      r_busy    <= 1'b0;
      r_note    <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= w_hit_or;
      r_pending <= w_pending_nxt;
      r_hp      <= w_hp_nxt;
      r_half    <= w_half_nxt;
      r_tick    <= w_tick_nxt;
      r_ms      <= w_ms_nxt;
      r_buzz    <= w_buzz_nxt;
      r_busy    <= w_busy_nxt;
      r_note    <= w_note_nxt;
    end
  end

  assign buzz    = r_buzz;
  assign busy    = r_busy;
  assign pending = r_pending;
  assign note_id = r_note;

endmodule
